// File: rtl/udma_jtag_rx_framer.sv
// JTAG RX framer: parses header / payload / checksum packets from the CDC FIFO
// and forwards payload words to the uDMA RX channel through a 1-deep output register.
module udma_jtag_rx_framer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [31:0]          out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    input  logic                 cfg_en_i,
    output logic [7:0]           tag_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic                 evt_done_o,
    output logic                 evt_err_o,
    output logic                 busy_o
);
    localparam logic [7:0] MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2
    } state_t;

    state_t                r_state;
    logic [31:0]           r_out_data;
    logic                  r_out_valid;
    logic [31:0]           r_xor;
    logic [15:0]           r_remain;
    logic [7:0]            r_tag;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic                  r_evt_done;
    logic                  r_evt_err;

    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;

    // Counters roll over from all-ones to zero.
    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        return v + CNT_WIDTH'(1);
    endfunction

    // Ready depends only on state, enable and the output side, never on in_valid_i.
    always_comb begin
        w_in_ready = 1'b0;
        if (!rst_i) begin
            unique case (r_state)
                HDR:     w_in_ready = cfg_en_i;
                PAYLOAD: w_in_ready = !r_out_valid || out_ready_i;
                CSUM:    w_in_ready = 1'b1;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_in_fire  = in_valid_i && w_in_ready;
    assign w_out_fire = r_out_valid && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= HDR;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_xor       <= '0;
            r_remain    <= '0;
            r_tag       <= '0;
            r_pkt_cnt   <= '0;
            r_err_cnt   <= '0;
            r_evt_done  <= 1'b0;
            r_evt_err   <= 1'b0;
        end else begin
            r_evt_done <= 1'b0;
            r_evt_err  <= 1'b0;
            // Drain first so a same-cycle reload below keeps valid high.
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                HDR: begin
                    if (w_in_fire) begin
                        if (in_data_i[31:24] == MAGIC) begin
                            r_tag    <= in_data_i[23:16];
                            r_remain <= in_data_i[15:0];
                            r_xor    <= '0;
                            r_state  <= (in_data_i[15:0] != 16'd0) ? PAYLOAD : CSUM;
                        end else begin
                            r_evt_err <= 1'b1;
                            r_err_cnt <= cnt_inc(r_err_cnt);
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_in_fire) begin
                        r_out_data  <= in_data_i;
                        r_out_valid <= 1'b1;
                        r_xor       <= r_xor ^ in_data_i;
                        r_remain    <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (w_in_fire) begin
                        r_pkt_cnt  <= cnt_inc(r_pkt_cnt);
                        r_evt_done <= 1'b1;
                        if (in_data_i != r_xor) begin
                            r_evt_err <= 1'b1;
                            r_err_cnt <= cnt_inc(r_err_cnt);
                        end
                        r_state <= HDR;
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_data_o  = r_out_data;
    assign out_valid_o = r_out_valid;
    assign tag_o       = r_tag;
    assign pkt_cnt_o   = r_pkt_cnt;
    assign err_cnt_o   = r_err_cnt;
    assign evt_done_o  = r_evt_done;
    assign evt_err_o   = r_evt_err;
    assign busy_o      = (r_state != HDR);

endmodule

// File: tb/tb_udma_jtag_rx_framer.sv
// Bench for udma_jtag_rx_framer: packet-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_udma_jtag_rx_framer;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   in_data_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [31:0]   out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic          cfg_en_i = 1'b1;
    logic [7:0]    tag_o;
    logic [CW-1:0] pkt_cnt_o;
    logic [CW-1:0] err_cnt_o;
    logic          evt_done_o;
    logic          evt_err_o;
    logic          busy_o;

    udma_jtag_rx_framer #(.CNT_WIDTH(CW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .cfg_en_i    (cfg_en_i),
        .tag_o       (tag_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .err_cnt_o   (err_cnt_o),
        .evt_done_o  (evt_done_o),
        .evt_err_o   (evt_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stimulus controls
    int  or_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int  cfg_mode = 0;  // 0: follow cfg_val, 1: random
    bit  cfg_val = 1'b1;
    bit  gaps = 1'b0;
    logic [31:0] tx[$];

    always @(negedge clk_i) begin
        case (or_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = ($urandom_range(0, 2) != 0);
            default: out_ready_i = 1'b0;
        endcase
        if (cfg_mode == 1) cfg_en_i = ($urandom_range(0, 3) != 0);
        else               cfg_en_i = cfg_val;
    end

    // Reference model: packet parser over accepted words
    bit          started = 1'b0;
    int          m_phase;      // 0 expecting header, 1 payload, 2 checksum
    int          m_left;
    logic [31:0] m_xor;
    logic [31:0] m_od;
    bit          m_ov;
    logic [7:0]  m_tag;
    int          m_pkt;
    int          m_err;
    bit          m_done;
    bit          m_errp;
    bit          m_rdy;
    logic [31:0] m_w;

    logic [31:0] outq[$];
    int n_done_seen, n_err_seen, n_both_seen;

    always @(negedge clk_i) begin
        #2;
        if (rst_i)             m_rdy = 1'b0;
        else if (m_phase == 0) m_rdy = cfg_en_i;
        else if (m_phase == 1) m_rdy = !m_ov || out_ready_i;
        else                   m_rdy = 1'b1;

        if (started) begin
            chk("in_ready",  32'(in_ready_o),  32'(m_rdy));
            chk("out_valid", 32'(out_valid_o), 32'(m_ov));
            chk("out_data",  out_data_o,       m_od);
            chk("tag",       32'(tag_o),       32'(m_tag));
            chk("pkt_cnt",   32'(pkt_cnt_o),   32'(m_pkt % (1 << CW)));
            chk("err_cnt",   32'(err_cnt_o),   32'(m_err % (1 << CW)));
            chk("evt_done",  32'(evt_done_o),  32'(m_done));
            chk("evt_err",   32'(evt_err_o),   32'(m_errp));
            chk("busy",      32'(busy_o),      32'(m_phase != 0));
            if (evt_done_o) n_done_seen++;
            if (evt_err_o) n_err_seen++;
            if (evt_done_o && evt_err_o) n_both_seen++;
            if (!rst_i && out_valid_o && out_ready_i) outq.push_back(out_data_o);
        end

        if (rst_i) begin
            started = 1'b1;
            m_phase = 0; m_left = 0; m_xor = '0; m_od = '0; m_ov = 1'b0;
            m_tag = '0; m_pkt = 0; m_err = 0; m_done = 1'b0; m_errp = 1'b0;
        end else if (started) begin
            m_done = 1'b0;
            m_errp = 1'b0;
            if (m_ov && out_ready_i) m_ov = 1'b0;
            if (in_valid_i && m_rdy) begin
                m_w = in_data_i;
                if (m_phase == 0) begin
                    if (m_w[31:24] == 8'hA5) begin
                        m_tag = m_w[23:16];
                        m_left = int'(m_w[15:0]);
                        m_xor = '0;
                        m_phase = (m_left != 0) ? 1 : 2;
                    end else begin
                        m_errp = 1'b1;
                        m_err++;
                    end
                end else if (m_phase == 1) begin
                    m_od = m_w;
                    m_ov = 1'b1;
                    m_xor = m_xor ^ m_w;
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end else begin
                    m_pkt++;
                    m_done = 1'b1;
                    if (m_w != m_xor) begin
                        m_errp = 1'b1;
                        m_err++;
                    end
                    m_phase = 0;
                end
            end
        end
    end

    task automatic send_tx();
        int  t;
        bit  done;
        while (tx.size() > 0) begin
            t = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk_i);
                in_data_i  = tx[0];
                in_valid_i = (gaps && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                #1;
                if (in_valid_i && in_ready_o) begin
                    done = 1'b1;
                end else if (++t > 300) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    tx.delete();
                    in_valid_i = 1'b0;
                    return;
                end
            end
            void'(tx.pop_front());
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            #3;
            if (!out_valid_o && !busy_o) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic clear_stats();
        outq.delete();
        n_done_seen = 0;
        n_err_seen = 0;
        n_both_seen = 0;
    endtask

    task automatic push_pkt_a(input logic [31:0] csum);
        tx.push_back(32'hA5070003);
        tx.push_back(32'h11111111);
        tx.push_back(32'h22222222);
        tx.push_back(32'h44444444);
        tx.push_back(csum);
    endtask

    task automatic check_a_outputs(input string nm);
        chk({nm, "_outq_n"}, 32'(outq.size()), 32'd3);
        if (outq.size() == 3) begin
            chk({nm, "_out0"}, outq[0], 32'h11111111);
            chk({nm, "_out1"}, outq[1], 32'h22222222);
            chk({nm, "_out2"}, outq[2], 32'h44444444);
        end
    endtask

    task automatic gen_pkt(input bit allow_bad);
        logic [31:0] junk;
        logic [31:0] x;
        logic [31:0] w;
        int len;
        if (allow_bad && $urandom_range(0, 5) == 0) begin
            junk = $urandom;
            if (junk[31:24] == 8'hA5) junk[31:24] = 8'h5A;
            tx.push_back(junk);
        end
        len = $urandom_range(0, 4);
        tx.push_back({8'hA5, 8'($urandom), 16'(len)});
        x = '0;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            x = x ^ w;
            tx.push_back(w);
        end
        if (allow_bad && $urandom_range(0, 3) == 0) x = x ^ 32'h0000_0100;
        tx.push_back(x);
    endtask

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #3;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_out_data",  out_data_o,       32'd0);
        chk("rst_tag",       32'(tag_o),       32'd0);
        chk("rst_pkt",       32'(pkt_cnt_o),   32'd0);
        chk("rst_err",       32'(err_cnt_o),   32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);

        // Packet A, stall-free
        clear_stats();
        push_pkt_a(32'h77777777);
        send_tx();
        wait_idle();
        check_a_outputs("A");
        chk("A_tag",  32'(tag_o),     32'h07);
        chk("A_pkt",  32'(pkt_cnt_o), 32'd1);
        chk("A_err",  32'(err_cnt_o), 32'd0);
        chk("A_done", 32'(n_done_seen), 32'd1);
        chk("A_errp", 32'(n_err_seen),  32'd0);

        // Backpressure during payload
        do_reset();
        clear_stats();
        tx.push_back(32'hA5070003);
        tx.push_back(32'h11111111);
        send_tx();
        or_mode = 2;
        tx.push_back(32'h22222222);
        tx.push_back(32'h44444444);
        tx.push_back(32'h77777777);
        fork
            send_tx();
            begin
                repeat (5) begin
                    @(negedge clk_i);
                    #3;
                    chk("bp_hold_data", out_data_o, 32'h11111111);
                    chk("bp_in_ready",  32'(in_ready_o), 32'd0);
                end
                or_mode = 0;
            end
        join
        wait_idle();
        check_a_outputs("BP");
        chk("BP_pkt", 32'(pkt_cnt_o), 32'd1);
        chk("BP_err", 32'(err_cnt_o), 32'd0);

        // Bad checksum
        do_reset();
        clear_stats();
        push_pkt_a(32'h00000000);
        send_tx();
        wait_idle();
        check_a_outputs("BC");
        chk("BC_both", 32'(n_both_seen), 32'd1);
        chk("BC_pkt",  32'(pkt_cnt_o),   32'd1);
        chk("BC_err",  32'(err_cnt_o),   32'd1);

        // Bad magic, then empty packet
        do_reset();
        clear_stats();
        tx.push_back(32'h12345678);
        tx.push_back(32'hA5FF0000);
        tx.push_back(32'h00000000);
        send_tx();
        wait_idle();
        chk("BM_tag",  32'(tag_o),       32'hFF);
        chk("BM_pkt",  32'(pkt_cnt_o),   32'd1);
        chk("BM_err",  32'(err_cnt_o),   32'd1);
        chk("BM_outq", 32'(outq.size()), 32'd0);
        chk("BM_errp", 32'(n_err_seen),  32'd1);

        // Disable in HDR, then drop enable mid-packet
        do_reset();
        clear_stats();
        cfg_val = 1'b0;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_data_i = 32'hA5070003;
        repeat (4) begin
            @(negedge clk_i);
            #3;
            chk("dis_in_ready", 32'(in_ready_o), 32'd0);
            chk("dis_busy",     32'(busy_o),     32'd0);
        end
        in_valid_i = 1'b0;
        cfg_val = 1'b1;
        tx.push_back(32'hA5070003);
        send_tx();
        cfg_val = 1'b0;
        tx.push_back(32'h11111111);
        tx.push_back(32'h22222222);
        tx.push_back(32'h44444444);
        tx.push_back(32'h77777777);
        send_tx();
        wait_idle();
        check_a_outputs("DIS");
        chk("DIS_pkt", 32'(pkt_cnt_o), 32'd1);
        cfg_val = 1'b1;

        // Reset mid-packet
        do_reset();
        tx.push_back(32'hA5070003);
        tx.push_back(32'h11111111);
        tx.push_back(32'h22222222);
        send_tx();
        do_reset();
        clear_stats();
        @(negedge clk_i);
        #3;
        chk("MR_out_valid", 32'(out_valid_o), 32'd0);
        chk("MR_out_data",  out_data_o,       32'd0);
        chk("MR_tag",       32'(tag_o),       32'd0);
        chk("MR_pkt",       32'(pkt_cnt_o),   32'd0);
        chk("MR_busy",      32'(busy_o),      32'd0);
        push_pkt_a(32'h77777777);
        send_tx();
        wait_idle();
        check_a_outputs("MR");
        chk("MR_pkt_after", 32'(pkt_cnt_o), 32'd1);
        chk("MR_done",      32'(n_done_seen), 32'd1);

        // Counter wrap with 16 good packets
        do_reset();
        for (int p = 0; p < 16; p++) gen_pkt(1'b0);
        send_tx();
        wait_idle();
        chk("wrap_pkt", 32'(pkt_cnt_o), 32'd0);
        chk("wrap_err", 32'(err_cnt_o), 32'd0);

        // Randomized traffic
        do_reset();
        or_mode = 1;
        cfg_mode = 1;
        gaps = 1'b1;
        for (int p = 0; p < 40; p++) gen_pkt(1'b1);
        send_tx();
        or_mode = 0;
        cfg_mode = 0;
        gaps = 1'b0;
        wait_idle();

        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
